zqh_riscv_test_sequencer: RTL and testbench
===========================================

Name: zqh_riscv_test_sequencer

Overview:
- Parametrised hardware successor to the single-test master: runs up to NUM_TESTS test agents in sequence instead of dispatching one named test.
- The set of tests is selected by a bit mask; each agent gets a start pulse and returns done/pass.
- Per-test timeout, optional stop-on-first-fail, and aggregate pass/fail/timeout counters.
- Sits in the riscv verification env between the test-selection front end and the per-test agents.

Parameters:
NUM_TESTS, 8, number of test channels (1..64)
IDX_W, $clog2(NUM_TESTS+1), width of the channel index and the counters
TMO_W, 32, timeout counter width

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  run request
cfg_ready  out  1  sequencer idle, can accept a request
cfg_mask  in  NUM_TESTS  bit i=1 -> run test i
cfg_timeout  in  TMO_W  max RUN cycles per test; 0 = no timeout
cfg_stop_on_fail  in  1  abort the remaining tests after the first failure
test_start  out  NUM_TESTS  one-hot, one-cycle start pulse
test_done  in  NUM_TESTS  per-channel completion (level or pulse)
test_pass  in  NUM_TESTS  per-channel result, sampled with test_done
busy  out  1  run in progress
cur_idx  out  IDX_W  channel currently scanned or running
finish  out  1  one-cycle pulse at the end of a run
result_pass  out  1  run passed; valid from finish until the next accept
err_no_test  out  1  last request had an empty mask
pass_cnt  out  IDX_W  tests passed
fail_cnt  out  IDX_W  tests failed, including timeouts
tmo_cnt  out  IDX_W  tests that timed out

Behaviour:
- Reset values:
  - State IDLE.
  - cfg_ready=1.
  - All other outputs 0: test_start, busy, cur_idx, finish, result_pass, err_no_test, all counters.
- Timer: 1 cycle in LAUNCH, then increments each RUN cycle.
- States: IDLE, SCAN, LAUNCH, RUN, DONE.
- IDLE:
  - cfg_ready=1.
  - Accept on cfg_valid&cfg_ready: latch mask, timeout and stop flag; clear counters, err_no_test, result_pass and idx.
  - Empty mask -> DONE with err_no_test=1.
  - Otherwise -> SCAN.
- SCAN (one index per cycle):
  - idx==NUM_TESTS -> DONE.
  - mask[idx]=1 -> LAUNCH.
  - Otherwise idx++.
- LAUNCH:
  - test_start[idx]=1 for exactly this cycle.
  - Clear timer; -> RUN.
- RUN, while waiting for the current channel:
  - test_done[idx]=1: sample test_pass[idx]; pass -> pass_cnt++, fail -> fail_cnt++.
  - Else if cfg_timeout!=0 and timer==cfg_timeout: fail_cnt++ and tmo_cnt++.
  - done and timeout in the same cycle: done wins, no timeout counted.
- RUN exit, after a result or timeout:
  - Failure with stop flag set -> DONE.
  - Otherwise idx++ -> SCAN.
- test_done/test_pass on channels other than idx are ignored in every state.
- DONE:
  - finish=1 for one cycle.
  - result_pass = (fail_cnt==0) & !err_no_test.
  - -> IDLE.
- busy=1 in SCAN, LAUNCH, RUN and DONE.
- Counters, result_pass and err_no_test hold until the next accept.
- cfg_valid outside IDLE is ignored; cfg_ready=0 there.
- Reset mid-run:
  - Return to IDLE next cycle and zero all outputs.
  - No further test_start pulses.
  - A pending test_done is ignored.
- Counters cannot overflow: at most NUM_TESTS tests per run.
- Latency: accept at cycle T -> first test_start no earlier than T+2 (SCAN at T+1, LAUNCH at T+2 when mask[0]=1).

Test Plan:
- Run all tests, all pass:
  - Stimulus: NUM_TESTS=4, mask=4'b1111, timeout=100; each agent raises done+pass 5 cycles after its start.
  - Required: test_start pulses in order on channels 0,1,2,3; finish with result_pass=1, pass_cnt=4, fail_cnt=0.
- Sparse mask with one failure, stop flag clear:
  - Stimulus: mask=4'b1010, stop=0; ch1 fails, ch3 passes.
  - Required: starts only on ch1 and ch3; pass_cnt=1, fail_cnt=1, result_pass=0.
- Stop on first fail:
  - Stimulus: mask=4'b0111, stop=1; ch0 fails.
  - Required: no start on ch1 or ch2; finish right after the ch0 result, fail_cnt=1.
- Timeout:
  - Stimulus: timeout=10; ch0 never responds.
  - Required: after 10 RUN cycles tmo_cnt=1 and fail_cnt=1; the scan advances to the next masked channel.
  - Variant: done on exactly timer=10 -> counted as pass, tmo_cnt=0.
- Empty mask:
  - Stimulus: mask=0.
  - Required: finish within 2 cycles of accept; err_no_test=1, result_pass=0, no test_start.
- Reset and ignored inputs:
  - Reset asserted during RUN -> next cycle in IDLE, busy=0, cfg_ready=1, counters 0.
  - done on a non-current channel -> ignored.
  - cfg_valid while busy -> ignored.

Source files
------------

// File: rtl/zqh_riscv_test_sequencer_if.sv
// rtl/zqh_riscv_test_sequencer_if.sv - run-request and per-test agent bundle for the test sequencer
interface zqh_riscv_test_sequencer_if #(
  parameter int NUM_TESTS = 8,
  parameter int IDX_W     = $clog2(NUM_TESTS + 1),
  parameter int TMO_W     = 32
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [NUM_TESTS-1:0] cfg_mask;
  logic [TMO_W-1:0]     cfg_timeout;
  logic                 cfg_stop_on_fail;
  logic [NUM_TESTS-1:0] test_start;
  logic [NUM_TESTS-1:0] test_done;
  logic [NUM_TESTS-1:0] test_pass;
  logic                 busy;
  logic [IDX_W-1:0]     cur_idx;
  logic                 finish;
  logic                 result_pass;
  logic                 err_no_test;
  logic [IDX_W-1:0]     pass_cnt;
  logic [IDX_W-1:0]     fail_cnt;
  logic [IDX_W-1:0]     tmo_cnt;

  modport slave (
    input  cfg_valid, cfg_mask, cfg_timeout, cfg_stop_on_fail, test_done, test_pass,
    output cfg_ready, test_start, busy, cur_idx, finish, result_pass, err_no_test,
           pass_cnt, fail_cnt, tmo_cnt
  );

  modport master (
    output cfg_valid, cfg_mask, cfg_timeout, cfg_stop_on_fail, test_done, test_pass,
    input  cfg_ready, test_start, busy, cur_idx, finish, result_pass, err_no_test,
           pass_cnt, fail_cnt, tmo_cnt
  );
endinterface

// File: rtl/zqh_riscv_test_sequencer.sv
// rtl/zqh_riscv_test_sequencer.sv - runs a masked set of test agents in order with timeout and result counters
module zqh_riscv_test_sequencer #(
  parameter int NUM_TESTS = 8,
  parameter int IDX_W     = $clog2(NUM_TESTS + 1),
  parameter int TMO_W     = 32
) (
  input logic                       clock,
  input logic                       reset,
  zqh_riscv_test_sequencer_if.slave bus
);
  // Channel vectors are zero-extended so idx==NUM_TESTS indexes a safe 0 bit.
  localparam int EXT_W = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, SCAN, LAUNCH, RUN, DONE} state_t;

  state_t               state, state_d;
  logic [IDX_W-1:0]     idx;
  logic [NUM_TESTS-1:0] mask_q;
  logic [TMO_W-1:0]     tmo_q;
  logic [TMO_W-1:0]     timer;
  logic                 stop_q;
  logic                 err_q;
  logic                 result_q;
  logic [IDX_W-1:0]     pass_cnt;
  logic [IDX_W-1:0]     fail_cnt;
  logic [IDX_W-1:0]     tmo_cnt;
  logic [EXT_W-1:0]     mask_ext;
  logic [EXT_W-1:0]     done_ext;
  logic [EXT_W-1:0]     pass_ext;
  logic                 at_end;
  logic                 cur_done;
  logic                 cur_pass;
  logic                 tmo_hit;
  logic                 accept;

  assign mask_ext = {{(EXT_W - NUM_TESTS){1'b0}}, mask_q};
  assign done_ext = {{(EXT_W - NUM_TESTS){1'b0}}, bus.test_done};
  assign pass_ext = {{(EXT_W - NUM_TESTS){1'b0}}, bus.test_pass};
  assign at_end   = (idx == IDX_W'(NUM_TESTS));
  assign cur_done = done_ext[idx];
  assign cur_pass = pass_ext[idx];
  assign tmo_hit  = (tmo_q != '0) && (timer == tmo_q);
  assign accept   = (state == IDLE) && bus.cfg_valid;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) state_d = (bus.cfg_mask == '0) ? DONE : SCAN;
      end
      SCAN: begin
        if (at_end)              state_d = DONE;
        else if (mask_ext[idx])  state_d = LAUNCH;
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        // A completion in the same cycle as the timeout wins over the timeout.
        if (cur_done)     state_d = (!cur_pass && stop_q) ? DONE : SCAN;
        else if (tmo_hit) state_d = stop_q ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      mask_q   <= '0;
      tmo_q    <= '0;
      stop_q   <= 1'b0;
      timer    <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (accept) begin
            mask_q   <= bus.cfg_mask;
            tmo_q    <= bus.cfg_timeout;
            stop_q   <= bus.cfg_stop_on_fail;
            idx      <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            tmo_cnt  <= '0;
            result_q <= 1'b0;
            err_q    <= (bus.cfg_mask == '0);
          end
        end
        SCAN: begin
          if (!at_end && !mask_ext[idx]) idx <= idx + 1'b1;
        end
        // The launch cycle counts as the first elapsed cycle, so RUN cycle N sees timer==N.
        LAUNCH: timer <= TMO_W'(1);
        RUN: begin
          timer <= timer + 1'b1;
          if (cur_done) begin
            if (cur_pass) pass_cnt <= pass_cnt + 1'b1;
            else          fail_cnt <= fail_cnt + 1'b1;
          end else if (tmo_hit) begin
            fail_cnt <= fail_cnt + 1'b1;
            tmo_cnt  <= tmo_cnt + 1'b1;
          end
          if (state_d == SCAN) idx <= idx + 1'b1;
        end
        DONE: result_q <= (fail_cnt == '0) && !err_q;
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.test_start  = (state == LAUNCH) ? (NUM_TESTS'(1) << idx) : '0;
  assign bus.finish      = (state == DONE);
  assign bus.result_pass = (state == DONE) ? ((fail_cnt == '0) && !err_q) : result_q;
  assign bus.err_no_test = err_q;
  assign bus.cur_idx     = idx;
  assign bus.pass_cnt    = pass_cnt;
  assign bus.fail_cnt    = fail_cnt;
  assign bus.tmo_cnt     = tmo_cnt;
endmodule

// File: tb/tb_zqh_riscv_test_sequencer.sv
// tb/tb_zqh_riscv_test_sequencer.sv - randomized self-checking bench for the test sequencer
module tb_zqh_riscv_test_sequencer;
  localparam int N    = 4;
  localparam int IW   = 3;
  localparam int TW   = 32;
  localparam int MAXC = 160;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  zqh_riscv_test_sequencer_if #(.NUM_TESTS(N), .IDX_W(IW), .TMO_W(TW)) bus ();

  zqh_riscv_test_sequencer #(.NUM_TESTS(N), .IDX_W(IW), .TMO_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Expected per-cycle timeline of one run; cycle 0 is the accept cycle.
  logic [N-1:0] e_start [MAXC];
  bit           e_busy  [MAXC];
  bit           e_fin   [MAXC];
  int           e_idx   [MAXC];
  int           e_pc    [MAXC];
  int           e_fc    [MAXC];
  int           e_tc    [MAXC];
  int           e_rp    [MAXC];
  int           e_err   [MAXC];
  int           run_ch  [MAXC];
  int           resp_cycle [N];

  int a_dly [N];   // RUN cycle on which the agent answers; 0 = never
  bit a_pas [N];

  int m_pc, m_fc, m_tc, m_rp, m_err;
  int prev_pc = 0, prev_fc = 0, prev_tc = 0, prev_rp = 0, prev_err = 0;
  int obs_fin, obs_first_start, obs_pc, obs_fc, obs_tc, obs_rp, obs_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void put(input int c, input bit busy, input int idx,
                              input logic [N-1:0] st, input bit fin, input int rch);
    e_busy[c]  = busy;
    e_idx[c]   = idx;
    e_start[c] = st;
    e_fin[c]   = fin;
    run_ch[c]  = rch;
    e_pc[c]    = m_pc;
    e_fc[c]    = m_fc;
    e_tc[c]    = m_tc;
    e_rp[c]    = m_rp;
    e_err[c]   = m_err;
  endfunction

  task automatic do_run(input logic [N-1:0] mask, input int tmo, input bit stop);
    int c, k, last, done_c;
    bit aborted, failed;
    for (int i = 0; i < N; i++) resp_cycle[i] = -1;
    m_pc = prev_pc; m_fc = prev_fc; m_tc = prev_tc; m_rp = prev_rp; m_err = prev_err;
    put(0, 1'b0, 0, '0, 1'b0, -1);
    m_pc = 0; m_fc = 0; m_tc = 0; m_rp = 0; m_err = (mask == '0);
    c = 1;
    if (mask == '0) begin
      done_c = 1;
      put(1, 1'b1, 0, '0, 1'b1, -1);
    end else begin
      aborted = 1'b0;
      last = 0;
      for (int i = 0; i < N && !aborted; i++) begin
        put(c, 1'b1, i, '0, 1'b0, -1);
        c++;
        if (mask[i]) begin
          put(c, 1'b1, i, N'(1) << i, 1'b0, -1);
          c++;
          if (a_dly[i] != 0 && (tmo == 0 || a_dly[i] <= tmo)) begin
            k = a_dly[i];
            resp_cycle[i] = c + k - 1;
            failed = !a_pas[i];
          end else begin
            k = tmo;
            failed = 1'b1;
          end
          for (int j = 0; j < k; j++) put(c + j, 1'b1, i, '0, 1'b0, i);
          c += k;
          if (resp_cycle[i] >= 0) begin
            if (a_pas[i]) m_pc++; else m_fc++;
          end else begin
            m_fc++; m_tc++;
          end
          if (failed && stop) begin
            aborted = 1'b1;
            last = i;
          end
        end
      end
      if (!aborted) begin
        put(c, 1'b1, N, '0, 1'b0, -1);
        c++;
        last = N;
      end
      done_c = c;
      m_rp = (m_fc == 0 && m_err == 0);
      put(done_c, 1'b1, last, '0, 1'b1, -1);
    end
    put(done_c + 1, 1'b0, 0, '0, 1'b0, -1);

    obs_fin = -1;
    obs_first_start = -1;
    for (int cc = 0; cc <= done_c + 1; cc++) begin
      bus.cfg_valid        = (cc == 0) ? 1'b1 : ((cc <= done_c) ? 1'($urandom) : 1'b0);
      bus.cfg_mask         = (cc == 0) ? mask : N'($urandom);
      bus.cfg_timeout      = (cc == 0) ? TW'(tmo) : TW'($urandom_range(0, 3));
      bus.cfg_stop_on_fail = (cc == 0) ? stop : 1'($urandom);
      bus.test_done        = N'($urandom);
      bus.test_pass        = N'($urandom);
      if (run_ch[cc] >= 0) begin
        bus.test_done[run_ch[cc]] = (cc == resp_cycle[run_ch[cc]]);
        if (cc == resp_cycle[run_ch[cc]]) bus.test_pass[run_ch[cc]] = a_pas[run_ch[cc]];
      end
      @(negedge clock);
      chk("test_start",  64'(bus.test_start),  64'(e_start[cc]));
      chk("busy",        64'(bus.busy),        64'(e_busy[cc]));
      chk("cfg_ready",   64'(bus.cfg_ready),   64'(!e_busy[cc]));
      chk("finish",      64'(bus.finish),      64'(e_fin[cc]));
      chk("pass_cnt",    64'(bus.pass_cnt),    64'(e_pc[cc]));
      chk("fail_cnt",    64'(bus.fail_cnt),    64'(e_fc[cc]));
      chk("tmo_cnt",     64'(bus.tmo_cnt),     64'(e_tc[cc]));
      chk("result_pass", 64'(bus.result_pass), 64'(e_rp[cc]));
      chk("err_no_test", 64'(bus.err_no_test), 64'(e_err[cc]));
      if (e_busy[cc]) chk("cur_idx", 64'(bus.cur_idx), 64'(e_idx[cc]));
      if (bus.finish === 1'b1 && obs_fin < 0) obs_fin = cc;
      if (bus.test_start !== '0 && obs_first_start < 0) obs_first_start = cc;
      if (cc == done_c + 1) begin
        obs_pc = bus.pass_cnt; obs_fc = bus.fail_cnt; obs_tc = bus.tmo_cnt;
        obs_rp = bus.result_pass; obs_err = bus.err_no_test;
      end
      @(posedge clock);
      #1;
    end
    prev_pc = m_pc; prev_fc = m_fc; prev_tc = m_tc; prev_rp = m_rp; prev_err = m_err;
  endtask

  initial begin
    logic [N-1:0] rmask;
    int rtmo;
    reset = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_mask = '0; bus.cfg_timeout = '0; bus.cfg_stop_on_fail = 1'b0;
    bus.test_done = '0; bus.test_pass = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 64'(bus.cfg_ready), 64'd1);
    chk("rst_busy",  64'(bus.busy),      64'd0);
    chk("rst_start", 64'(bus.test_start), 64'd0);
    chk("rst_idx",   64'(bus.cur_idx),   64'd0);
    chk("rst_cnts",  64'({bus.pass_cnt, bus.fail_cnt, bus.tmo_cnt, bus.finish, bus.result_pass, bus.err_no_test}), 64'd0);
    @(posedge clock);
    #1;

    // All four pass, 5 cycles after each start.
    for (int i = 0; i < N; i++) begin a_dly[i] = 5; a_pas[i] = 1'b1; end
    do_run(4'b1111, 100, 1'b0);
    chk("all_first_start", 64'(obs_first_start), 64'd2);
    chk("all_finish_cyc",  64'(obs_fin), 64'd30);
    chk("all_pass_cnt",    64'(obs_pc), 64'd4);
    chk("all_result",      64'(obs_rp), 64'd1);

    // Sparse mask, ch1 fails, ch3 passes.
    a_dly[1] = 4; a_pas[1] = 1'b0; a_dly[3] = 2; a_pas[3] = 1'b1;
    do_run(4'b1010, 50, 1'b0);
    chk("sparse_finish_cyc", 64'(obs_fin), 64'd14);
    chk("sparse_cnts", 64'({obs_pc[7:0], obs_fc[7:0]}), 64'h0101);
    chk("sparse_result", 64'(obs_rp), 64'd0);

    // Stop on first fail.
    a_dly[0] = 3; a_pas[0] = 1'b0;
    do_run(4'b0111, 50, 1'b1);
    chk("stop_finish_cyc", 64'(obs_fin), 64'd6);
    chk("stop_fail_cnt",   64'(obs_fc), 64'd1);

    // Timeout on ch0, ch1 answers exactly at timer==timeout.
    a_dly[0] = 0; a_dly[1] = 10; a_pas[1] = 1'b1;
    do_run(4'b0011, 10, 1'b0);
    chk("tmo_finish_cyc", 64'(obs_fin), 64'd28);
    chk("tmo_cnts", 64'({obs_pc[7:0], obs_fc[7:0], obs_tc[7:0]}), 64'h010101);

    // Empty mask.
    do_run(4'b0000, 5, 1'b0);
    chk("empty_finish_cyc", 64'(obs_fin), 64'd1);
    chk("empty_err", 64'(obs_err), 64'd1);
    chk("empty_result", 64'(obs_rp), 64'd0);
    chk("empty_no_start", 64'(obs_first_start), 64'hffffffffffffffff);

    for (int r = 0; r < 30; r++) begin
      rmask = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      rtmo = $urandom_range(0, 12);
      for (int i = 0; i < N; i++) begin
        a_dly[i] = (rtmo == 0) ? $urandom_range(1, 14) : $urandom_range(0, 14);
        a_pas[i] = 1'($urandom);
      end
      do_run(rmask, rtmo, 1'($urandom));
    end

    // Reset in the middle of RUN with a pending done.
    bus.cfg_valid = 1'b1; bus.cfg_mask = 4'b1111; bus.cfg_timeout = '0; bus.cfg_stop_on_fail = 1'b0;
    bus.test_done = '0;
    @(posedge clock);
    #1 bus.cfg_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    bus.test_done = 4'b0001; bus.test_pass = 4'b0001;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy",  64'(bus.busy),      64'd0);
    chk("midrst_ready", 64'(bus.cfg_ready), 64'd1);
    chk("midrst_cnts",  64'({bus.pass_cnt, bus.fail_cnt, bus.tmo_cnt, bus.result_pass, bus.err_no_test}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1 bus.test_done = N'($urandom);
      @(negedge clock);
      chk("midrst_no_start", 64'(bus.test_start), 64'd0);
      chk("midrst_idle_cnt", 64'({bus.pass_cnt, bus.fail_cnt, bus.busy}), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
